// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto a single slave memory port, with a per-transfer wait timeout.
// Latency: one idle arbitration cycle, then request/response pass straight through combinationally.
// Backpressure: the owner waits on s_ready; a TIMEOUT-cycle stall aborts the transfer with ERR_DATA and err.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 1: master 1 was served last
    logic [7:0]  cnt_q, cnt_d;

    logic        busy;
    logic        sel_vld;
    logic        tmo;
    logic        done;
    logic [31:0] rsp_dat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        busy    = (state_q == BUSY0) || (state_q == BUSY1);
        sel_vld = (state_q == BUSY0) ? m0_valid :
                  (state_q == BUSY1) ? m1_valid : 1'b0;
        // A real s_ready always beats a timeout landing on the same cycle.
        tmo     = busy && sel_vld && !s_ready && (cnt_q == CNT_LAST);
        done    = busy && sel_vld && (s_ready || tmo);
        rsp_dat = s_ready ? s_rdata : ERR_DATA;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (m0_valid && m1_valid) begin
                    state_d = last_grant_q ? BUSY0 : BUSY1;
                end else if (m0_valid) begin
                    state_d = BUSY0;
                end else if (m1_valid) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (!sel_vld) begin
                    // Owner withdrew mid-transfer: drop it without touching fairness state.
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (done) begin
                    state_d      = IDLE;
                    last_grant_d = (state_q == BUSY1);
                    cnt_d        = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        grant    = {state_q == BUSY1, state_q == BUSY0};
        s_valid  = sel_vld;
        s_addr   = 32'd0;
        s_wdata  = 32'd0;
        s_wstrb  = 4'd0;
        if (state_q == BUSY0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
        end else if (state_q == BUSY1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
        end
        m0_ready = done && (state_q == BUSY0);
        m1_ready = done && (state_q == BUSY1);
        m0_rdata = m0_ready ? rsp_dat : 32'd0;
        m1_rdata = m1_ready ? rsp_dat : 32'd0;
        err      = tmo;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed vector bench for mem_bus_arbiter: a cycle table plus timeout, collision and reset sequences.
module tb_mem_bus_arbiter;

    localparam logic [31:0] M0_ADDR  = 32'h0000_0040;
    localparam logic [31:0] M0_WDATA = 32'h0BAD_F00D;
    localparam logic [3:0]  M0_WSTRB = 4'b0000;
    localparam logic [31:0] M1_ADDR  = 32'h1000_0000;
    localparam logic [31:0] M1_WDATA = 32'hA5A5_A5A5;
    localparam logic [3:0]  M1_WSTRB = 4'b0011;
    localparam logic [31:0] ERRD     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [31:0] m0_addr = M0_ADDR, m0_wdata = M0_WDATA;
    logic [3:0]  m0_wstrb = M0_WSTRB;
    logic [31:0] m1_addr = M1_ADDR, m1_wdata = M1_WDATA;
    logic [3:0]  m1_wstrb = M1_WSTRB;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  grant;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int vec_idx  = 0;

    mem_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(ERRD)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        m0v;
        logic        m1v;
        logic        sr;
        logic [31:0] srd;
        logic [1:0]  gnt;
        logic        sv;
        logic        r0;
        logic        r1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        er;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic m0v, input logic m1v,
                                input logic sr, input logic [31:0] srd,
                                input logic [1:0] gnt, input logic sv,
                                input logic r0, input logic r1,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic er);
        vec_t v;
        v.rst_n = rst_n; v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
        v.gnt = gnt; v.sv = sv; v.r0 = r0; v.r1 = r1; v.rd0 = rd0; v.rd1 = rd1; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, vec_idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check the combinational outputs.
    task automatic run(input vec_t v);
        logic [31:0] ea, ew;
        logic [3:0]  es;
        @(negedge clk);
        resetn   = v.rst_n;
        m0_valid = v.m0v;
        m1_valid = v.m1v;
        s_ready  = v.sr;
        s_rdata  = v.srd;
        #1;
        ea = (v.gnt == 2'b01) ? M0_ADDR  : (v.gnt == 2'b10) ? M1_ADDR  : 32'd0;
        ew = (v.gnt == 2'b01) ? M0_WDATA : (v.gnt == 2'b10) ? M1_WDATA : 32'd0;
        es = (v.gnt == 2'b01) ? M0_WSTRB : (v.gnt == 2'b10) ? M1_WSTRB : 4'd0;
        chk("grant",    32'(grant),    32'(v.gnt));
        chk("s_valid",  32'(s_valid),  32'(v.sv));
        chk("s_addr",   s_addr,        ea);
        chk("s_wdata",  s_wdata,       ew);
        chk("s_wstrb",  32'(s_wstrb),  32'(es));
        chk("m0_ready", 32'(m0_ready), 32'(v.r0));
        chk("m1_ready", 32'(m1_ready), 32'(v.r1));
        chk("m0_rdata", m0_rdata,      v.rd0);
        chk("m1_rdata", m1_rdata,      v.rd1);
        chk("err",      32'(err),      32'(v.er));
        vec_idx++;
    endtask

    vec_t tbl[$];

    initial begin
        // rst  m0v  m1v  sr   srd            gnt    sv   r0   r1   rd0            rd1            err
        tbl.push_back(mk(0, 1, 0, 1, 32'h11,       2'b00, 0, 0, 0, 32'h0,         32'h0,         0)); // in reset
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0)); // idle arb
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 1, 32'h12345678, 2'b01, 1, 1, 0, 32'h12345678, 32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0)); // m1 write
        tbl.push_back(mk(1, 0, 1, 0, 32'h0,        2'b10, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 0, 1, 1, 32'h77,       2'b10, 1, 0, 1, 32'h0,         32'h77,        0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0)); // valid drop
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,        2'b01, 1, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h55,       2'b01, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0)); // tie: m0 still due
        tbl.push_back(mk(1, 1, 1, 1, 32'hA1,       2'b01, 1, 1, 0, 32'hA1,        32'h0,         0));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 1, 1, 32'hB2,       2'b10, 1, 0, 1, 32'h0,         32'hB2,        0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,         32'h0,         0));

        foreach (tbl[i]) run(tbl[i]);

        // Timeout with m1 queued behind: abort on the 16th busy cycle, then m1 is served.
        run(mk(1, 1, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        for (int c = 1; c <= 15; c++)
            run(mk(1, 1, 1, 0, 32'h0, 2'b01, 1, 0, 0, 32'h0, 32'h0, 0));
        run(mk(1, 1, 1, 0, 32'h0,  2'b01, 1, 1, 0, ERRD,  32'h0,  1));
        run(mk(1, 0, 1, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 32'h0,  0));
        run(mk(1, 0, 1, 1, 32'hC3, 2'b10, 1, 0, 1, 32'h0, 32'hC3, 0));
        run(mk(1, 0, 0, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 32'h0,  0));

        // s_ready on the timeout cycle returns real data without err.
        run(mk(1, 1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        for (int c = 1; c <= 15; c++)
            run(mk(1, 1, 0, 0, 32'h0, 2'b01, 1, 0, 0, 32'h0, 32'h0, 0));
        run(mk(1, 1, 0, 1, 32'hCAFEF00D, 2'b01, 1, 1, 0, 32'hCAFEF00D, 32'h0, 0));
        run(mk(1, 0, 0, 0, 32'h0,        2'b00, 0, 0, 0, 32'h0,        32'h0, 0));

        // Reset in BUSY1 kills the transfer; afterwards a tie goes m0, m1, m0, m1.
        run(mk(1, 0, 1, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        run(mk(1, 0, 1, 0, 32'h0,  2'b10, 1, 0, 0, 32'h0, 32'h0, 0));
        run(mk(0, 0, 1, 1, 32'h99, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        run(mk(0, 1, 1, 1, 32'h99, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        run(mk(1, 1, 1, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                run(mk(1, 1, 1, 1, 32'h100 + k, 2'b01, 1, 1, 0, 32'h100 + k, 32'h0, 0));
            else
                run(mk(1, 1, 1, 1, 32'h100 + k, 2'b10, 1, 0, 1, 32'h0, 32'h100 + k, 0));
            run(mk(1, 1, 1, 0, 32'h0, 2'b00, 0, 0, 0, 32'h0, 32'h0, 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
